// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain controller: default sizes and FSM state encoding.
package fifo_pkg;

  localparam int unsigned DefaultFifoWidth = 16;
  localparam int unsigned DefaultFifoDepth = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } drain_state_e;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// Bundles the FIFO-side, stream-side and status signals of the drain controller.
interface fifo_drain_ctrl_if #(
  parameter int unsigned FIFO_WIDTH = fifo_pkg::DefaultFifoWidth
);

  logic                  enable;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  busy;
  logic [15:0]           pop_count;
  logic                  err_underflow;

  modport master (
    input  enable, fifo_empty, fifo_underflow, fifo_data_out, m_ready,
    output fifo_rd_en, m_valid, m_data, busy, pop_count, err_underflow
  );

  modport slave (
    output enable, fifo_empty, fifo_underflow, fifo_data_out, m_ready,
    input  fifo_rd_en, m_valid, m_data, busy, pop_count, err_underflow
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; head entry drives the registered output.
module fifo_skid_buf #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       occupancy_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign pop  = rd_en_i && (cnt_q != 2'd0);
  // A write into a full buffer is only legal when the head leaves in the same cycle.
  assign push = wr_en_i && ((cnt_q != 2'd2) || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q;
    if (push) mem_d[wr_ptr_q] = wr_data_i;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o     = (cnt_q != 2'd0);
  assign data_o      = mem_q[rd_ptr_q];
  assign occupancy_o = cnt_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Pops words from an upstream FIFO into a skid buffer feeding a valid/ready stream,
// draining buffered and in-flight words when enable drops.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DefaultFifoWidth,
  parameter int unsigned SKID_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  fifo_drain_ctrl_if.master  bus
);

  drain_state_e state_q, state_d;
  logic         inflight_q;
  logic [15:0]  pop_count_q;
  logic         err_q;
  logic [1:0]   occ;
  logic         hs;
  logic [2:0]   load;
  logic         rd_en;

  assign hs = bus.m_valid && bus.m_ready;
  // Slots that will be taken next cycle if nothing new is issued.
  assign load = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, hs};

  fifo_skid_buf #(
    .Width (FIFO_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (inflight_q),
    .wr_data_i   (bus.fifo_data_out),
    .rd_en_i     (bus.m_ready),
    .valid_o     (bus.m_valid),
    .data_o      (bus.m_data),
    .occupancy_o (occ)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.enable) state_d = RUN;
      RUN:   if (!bus.enable) state_d = DRAIN;
      DRAIN: begin
        if (bus.enable)                          state_d = RUN;
        else if (!inflight_q && (occ == 2'd0))   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en    = rst_n && (state_q == RUN) && !bus.fifo_empty && (load < 3'(SKID_DEPTH));
    bus.busy = (state_q != IDLE);
  end

  assign bus.fifo_rd_en = rd_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q  <= 1'b0;
      pop_count_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (inflight_q)         pop_count_q <= pop_count_q + 16'd1;
      if (bus.fifo_underflow) err_q       <= 1'b1;
    end
  end

  assign bus.pop_count     = pop_count_q;
  assign bus.err_underflow = err_q;

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data word width in bits.
REQ-002 Parameter SKID_DEPTH, default 2, output buffer entries (fixed at 2; other values unsupported).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  1 = fetch from FIFO; 0 = stop fetching and drain buffered words.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_underflow  input  1  FIFO underflow flag.
REQ-008 fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted rd_en.
REQ-009 fifo_rd_en  output  1  pop request to FIFO.
REQ-010 m_valid  output  1  output word valid.
REQ-011 m_ready  input  1  downstream accepts the word when m_valid && m_ready.
REQ-012 m_data  output  FIFO_WIDTH  output word.
REQ-013 busy  output  1  1 while state != IDLE.
REQ-014 pop_count  output  16  count of completed FIFO pops, wraps 0xFFFF->0.
REQ-015 err_underflow  output  1  sticky; set when fifo_underflow is sampled high.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on enable=1; RUN->DRAIN on enable=0; DRAIN->RUN on enable=1; DRAIN->IDLE when no pop is in flight and the skid buffer is empty.
REQ-017 fifo_rd_en is combinational: 1 only in RUN, with fifo_empty=0, and (occupancy + inflight - (m_valid && m_ready)) < 2.
REQ-018 inflight is a 1-bit register set to fifo_rd_en each cycle; when inflight=1, fifo_data_out is written into the skid buffer that cycle.
REQ-019 fifo_rd_en is never asserted while fifo_empty=1, so a correct FIFO never flags underflow due to this block.
REQ-020 Skid buffer is a 2-entry FIFO with registered output; m_data/m_valid come from the head entry; order is strictly preserved.
REQ-021 Simultaneous buffer write (inflight) and read (handshake) in the same cycle: both take effect; occupancy unchanged.
REQ-022 With m_ready held at 1 and the FIFO non-empty, throughput is 1 word/cycle after 2 cycles of initial latency (rd_en at cycle 0, m_valid at cycle 2).
REQ-023 m_data and m_valid hold stable while m_valid=1 and m_ready=0.
REQ-024 pop_count increments by 1 each cycle inflight=1.
REQ-025 err_underflow is set on any cycle fifo_underflow=1 and is cleared only by reset.
REQ-026 enable dropping in the same cycle as an issued rd_en: the in-flight word is still captured and delivered in DRAIN.

Reset
REQ-027 When rst_n=0 at a clock edge, the following reset: state=IDLE, inflight=0, occupancy=0, m_valid=0, m_data=0, pop_count=0, err_underflow=0, busy=0.
REQ-028 fifo_rd_en is 0 while rst_n=0.
REQ-029 Reset mid-transfer discards buffered and in-flight words; the first word after reset comes from a fresh pop.

Structure
REQ-030 Shared package fifo_pkg holds the FIFO_WIDTH default (16), the FIFO_DEPTH default (8), and the drain_state_e enum (IDLE, RUN, DRAIN).
REQ-031 The skid buffer is the sub-module fifo_skid_buf (2-entry, same clk/rst_n); the FSM, rd_en logic and counters live in fifo_drain_ctrl.

Verification
REQ-032 Load the FIFO with 0x0001..0x0008, enable=1, m_ready=1: m_data = 0x0001..0x0008 on 8 consecutive cycles starting cycle 2; pop_count=8; fifo_rd_en low once fifo_empty=1; err_underflow=0.
REQ-033 FIFO holds 5 words, m_ready=0 for 10 cycles: exactly 2 pops issued, m_valid=1 with m_data=word0 stable; then m_ready=1 gives word0..word4 in order with no duplicates.
REQ-034 m_ready toggles 1,0,1,0 during streaming of 0xA0..0xA7: all 8 words delivered in order, none lost or duplicated.
REQ-035 Drop enable in the cycle a pop is issued with 2 words buffered: state goes DRAIN, 3 words delivered, then IDLE and busy=0; no further fifo_rd_en.
REQ-036 Assert rst_n=0 for 1 cycle with m_valid=1: next cycle m_valid=0, pop_count=0, state=IDLE; force fifo_underflow=1 for 1 cycle afterwards: err_underflow=1 and stays 1 until the next reset.
